// File: rtl/vga_timing_monitor_pkg.sv
// vga_timing_monitor_pkg: state encoding, default 640x480@60 timing and sync polarity helper
package vga_timing_monitor_pkg;
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
    localparam int DEF_H_TOTAL     = 800;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_V_TOTAL     = 525;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_H_ACT_START = 144;
    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_V_ACT_START = 35;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int SYNC_ACTIVE_LOW = 0;
    function automatic logic sync_active(input logic lvl, input logic pol);
        return lvl ~^ pol;
    endfunction
endpackage

// File: rtl/vga_timing_monitor_sync_period_check.sv
// sync_period_check: counts ticks since the last assertion edge and checks period and asserted width
module sync_period_check #(
    parameter int TOTAL = 800,
    parameter int WIDTH = 96,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_tick,
    input  logic             i_level,
    input  logic             i_edge,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_period_err,
    output logic             o_width_err
);
    logic [CNT_W-1:0] r_cnt, r_width, w_cnt_inc, w_width_inc;
    logic             r_level, w_fall;
    // counts include the tick of the edge cycle, so at the next edge r_cnt is the full period
    assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(i_tick);
    assign w_width_inc = (&r_width) ? r_width : r_width + CNT_W'(i_tick);
    assign w_fall      = r_level & ~i_level;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_width <= '0;
            r_level <= 1'b0;
        end else begin
            r_level <= i_level;
            r_cnt   <= i_edge ? CNT_W'(i_tick) : w_cnt_inc;
            r_width <= i_edge ? CNT_W'(i_tick) : (i_level ? w_width_inc : r_width);
        end
    end
    assign o_cnt        = r_cnt;
    assign o_period_err = i_edge && (r_cnt != CNT_W'(TOTAL));
    assign o_width_err  = w_fall && (r_width != CNT_W'(WIDTH));
endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: checks VGA sync timing and active pixel count, publishes one result and checksum per frame
module vga_timing_monitor
    import vga_timing_monitor_pkg::*;
#(
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int H_ACT_START = DEF_H_ACT_START,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACT_START = DEF_V_ACT_START,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int SYNC_POL    = SYNC_ACTIVE_LOW,
    parameter int RGB_W       = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             h_sync,
    input  logic             v_sync,
    input  logic [RGB_W-1:0] rgb_in,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [4:0]       err_flags,
    output logic             locked,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] frame_sum
);
    localparam logic POL = 1'(SYNC_POL);
    state_t           r_state, w_state_nxt;
    logic             r_hs_q, r_hs_d, r_vs_q, r_vs_d;
    logic [RGB_W-1:0] r_rgb_q, r_rgb_d;
    logic             w_hs_lvl, w_vs_lvl, w_hs_edge, w_vs_edge;
    logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
    logic             w_h_total_err, w_h_sync_err, w_v_total_err, w_v_sync_err;
    logic             w_pix_act, w_publish;
    logic [4:0]       r_err, w_err_now, w_err_all, r_flags;
    logic [CNT_W-1:0] r_sum, w_sum_nxt, r_frame_sum, r_count;
    logic [31:0]      r_pix, w_pix_nxt;
    logic             r_done, r_ok;
    assign w_hs_lvl  = sync_active(r_hs_q, POL);
    assign w_vs_lvl  = sync_active(r_vs_q, POL);
    assign w_hs_edge = w_hs_lvl & ~sync_active(r_hs_d, POL);
    assign w_vs_edge = w_vs_lvl & ~sync_active(r_vs_d, POL);
    // syncs reset to the inactive level so reset itself never fakes an assertion edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs_q  <= ~POL;
            r_hs_d  <= ~POL;
            r_vs_q  <= ~POL;
            r_vs_d  <= ~POL;
            r_rgb_q <= '0;
            r_rgb_d <= '0;
        end else begin
            r_hs_q  <= h_sync;
            r_hs_d  <= r_hs_q;
            r_vs_q  <= v_sync;
            r_vs_d  <= r_vs_q;
            r_rgb_q <= rgb_in;
            r_rgb_d <= r_rgb_q;
        end
    end
    sync_period_check #(.TOTAL(H_TOTAL), .WIDTH(H_SYNC), .CNT_W(CNT_W)) u_h_check (
        .clk          (clk),
        .reset        (reset),
        .i_tick       (1'b1),
        .i_level      (w_hs_lvl),
        .i_edge       (w_hs_edge),
        .o_cnt        (w_h_cnt),
        .o_period_err (w_h_total_err),
        .o_width_err  (w_h_sync_err)
    );
    sync_period_check #(.TOTAL(V_TOTAL), .WIDTH(V_SYNC), .CNT_W(CNT_W)) u_v_check (
        .clk          (clk),
        .reset        (reset),
        .i_tick       (w_hs_edge),
        .i_level      (w_vs_lvl),
        .i_edge       (w_vs_edge),
        .o_cnt        (w_v_cnt),
        .o_period_err (w_v_total_err),
        .o_width_err  (w_v_sync_err)
    );
    // w_h_cnt is one ahead of the column index and lines up with the twice-registered pixel
    assign w_pix_act = (w_h_cnt > CNT_W'(H_ACT_START)) && (w_h_cnt <= CNT_W'(H_ACT_START + H_ACTIVE)) &&
                       (w_v_cnt > CNT_W'(V_ACT_START)) && (w_v_cnt <= CNT_W'(V_ACT_START + V_ACTIVE));
    assign w_sum_nxt = w_pix_act ? ({r_sum[CNT_W-2:0], r_sum[CNT_W-1]} ^ CNT_W'(r_rgb_d)) : r_sum;
    assign w_pix_nxt = r_pix + 32'(w_pix_act);
    assign w_err_now = {w_vs_edge && (w_pix_nxt != 32'(H_ACTIVE * V_ACTIVE)),
                        w_v_sync_err, w_v_total_err, w_h_sync_err, w_h_total_err};
    assign w_err_all = r_err | w_err_now;
    always_comb begin
        w_publish   = w_vs_edge && (r_state != SEARCH);
        w_state_nxt = !w_vs_edge ? r_state :
                      (r_state == SEARCH || |w_err_all) ? MEASURE : LOCKED;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SEARCH;
            r_err       <= '0;
            r_sum       <= '0;
            r_pix       <= '0;
            r_done      <= 1'b0;
            r_ok        <= 1'b0;
            r_flags     <= '0;
            r_frame_sum <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_publish;
            r_err   <= w_vs_edge ? '0 : w_err_all;
            r_sum   <= w_vs_edge ? '0 : w_sum_nxt;
            r_pix   <= w_vs_edge ? '0 : w_pix_nxt;
            if (w_publish) begin
                r_ok        <= ~|w_err_all;
                r_flags     <= w_err_all;
                r_frame_sum <= w_sum_nxt;
                r_count     <= r_count + CNT_W'(1);
            end
        end
    end
    assign frame_done  = r_done;
    assign frame_ok    = r_ok;
    assign err_flags   = r_flags;
    assign locked      = (r_state == LOCKED);
    assign frame_count = r_count;
    assign frame_sum   = r_frame_sum;
endmodule
